// File: rtl/shiftreg_reader.sv
// Receive-side frame reader: watches the delay-line tap for a SYNC marker,
// captures FRAME_LEN payload bytes, then drains them through a valid/ready port.
module shiftreg_reader #(
  parameter int         DEPTH     = 16,
  parameter int         FRAME_LEN = 8,
  parameter logic [7:0] SYNC      = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] din,
  input  logic       rd_ready,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       overflow
);

  localparam int            CW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] wr_cnt_q, wr_cnt_d;
  logic [CW-1:0] rd_cnt_q, rd_cnt_d;
  logic          rd_valid_q, rd_valid_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          busy_q, busy_d;
  logic          overflow_q, overflow_d;
  logic          wr_en;
  logic [7:0]    mem_q [DEPTH];

  // Next-state, counter and output computation
  always_comb begin
    state_d    = state_q;
    wr_cnt_d   = wr_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    overflow_d = overflow_q;
    wr_en      = 1'b0;
    case (state_q)
      IDLE: begin
        if (ena && (din == SYNC)) begin
          state_d  = CAPTURE;
          wr_cnt_d = {CW{1'b0}};
        end else begin
          state_d  = IDLE;
        end
      end
      CAPTURE: begin
        if (ena) begin
          wr_en = 1'b1;
          if (wr_cnt_q == LAST) begin
            state_d    = DRAIN;
            rd_cnt_d   = {CW{1'b0}};
            rd_valid_d = 1'b1;
            // With a one-byte frame, entry 0 is being written this very cycle
            rd_data_d  = (wr_cnt_q == {CW{1'b0}}) ? din : mem_q[0];
          end else begin
            wr_cnt_d = wr_cnt_q + CW'(1);
          end
        end else begin
          state_d = CAPTURE;
        end
      end
      DRAIN: begin
        if (ena && (din == SYNC)) begin
          overflow_d = 1'b1;
        end else begin
          overflow_d = overflow_q;
        end
        if (rd_valid_q && rd_ready) begin
          if (rd_cnt_q == LAST) begin
            state_d    = IDLE;
            rd_valid_d = 1'b0;
            rd_data_d  = 8'h00;
          end else begin
            rd_cnt_d  = rd_cnt_q + CW'(1);
            rd_data_d = mem_q[rd_cnt_q + CW'(1)];
          end
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d    = IDLE;
        rd_valid_d = 1'b0;
        rd_data_d  = 8'h00;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, counter and registered-output update with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_cnt_q   <= {CW{1'b0}};
      rd_cnt_q   <= {CW{1'b0}};
      rd_valid_q <= 1'b0;
      rd_data_q  <= 8'h00;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
    end
  end

  // Frame buffer write port; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_cnt_q] <= din;
    end else begin
      mem_q[wr_cnt_q] <= mem_q[wr_cnt_q];
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_shiftreg_reader.sv
// Scoreboard bench for shiftreg_reader: frame-level reference model feeds an
// expected-byte queue that a negedge monitor drains and compares.
module tb_shiftreg_reader;
  localparam int         FL   = 8;
  localparam logic [7:0] SYNC = 8'hA5;

  logic       clk = 1'b0;
  logic       rst_n, ena, rd_ready;
  logic [7:0] din;
  logic       rd_valid, busy, overflow;
  logic [7:0] rd_data;

  logic       ena1, rd_ready1;
  logic [7:0] din1;
  logic       rd_valid1, busy1, overflow1;
  logic [7:0] rd_data1;

  int vectors = 0;
  int miscompares = 0;
  bit mon_en = 1'b0;
  int ready_mode = 0;

  int               m_mode = 0;
  logic [7:0]       cap_q[$];
  logic [7:0]       exp_q[$];
  int               remaining = 0;
  logic             exp_ovf = 1'b0;

  shiftreg_reader #(.DEPTH(16), .FRAME_LEN(FL), .SYNC(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .din(din), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy), .overflow(overflow)
  );

  shiftreg_reader #(.DEPTH(16), .FRAME_LEN(1), .SYNC(SYNC)) dut1 (
    .clk(clk), .rst_n(rst_n), .ena(ena1), .din(din1), .rd_ready(rd_ready1),
    .rd_valid(rd_valid1), .rd_data(rd_data1), .busy(busy1), .overflow(overflow1)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Frame-level reference: hunt for SYNC, collect FL bytes, hand them to the scoreboard
  always @(posedge clk) begin
    if (!rst_n) begin
      m_mode = 0;
      cap_q.delete();
      exp_q.delete();
      remaining = 0;
      exp_ovf = 1'b0;
    end else begin
      case (m_mode)
        0: if (ena && din == SYNC) begin
             m_mode = 1;
             cap_q.delete();
           end
        1: if (ena) begin
             cap_q.push_back(din);
             if (cap_q.size() == FL) begin
               foreach (cap_q[i]) exp_q.push_back(cap_q[i]);
               remaining = FL;
               m_mode = 2;
             end
           end
        default: begin
          if (ena && din == SYNC) exp_ovf = 1'b1;
          if (rd_ready) begin
            remaining--;
            if (remaining == 0) m_mode = 0;
          end
        end
      endcase
    end
  end

  // Monitor: compare presented outputs against the model and pop on transfer
  always @(negedge clk) begin
    logic [7:0] popped;
    if (mon_en) begin
      check("busy", {7'd0, busy}, {7'd0, m_mode != 0});
      check("overflow", {7'd0, overflow}, {7'd0, exp_ovf});
      check("rd_valid", {7'd0, rd_valid}, {7'd0, m_mode == 2});
      if (m_mode == 2) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_empty", 8'd1, 8'd0);
        end else begin
          check("rd_data", rd_data, exp_q[0]);
          if (rd_ready) popped = exp_q.pop_front();
        end
      end else begin
        check("rd_data_idle", rd_data, 8'h00);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
    rd_ready = (ready_mode == 1) ? 1'b1 :
               (ready_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int ngap);
    for (int i = 0; i < ngap; i++) begin
      tick();
      ena = 1'b0;
      din = 8'($urandom_range(0, 255));
    end
    tick();
    ena = 1'b1;
    din = b;
  endtask

  task automatic wait_idle(input bit noise);
    int n = 0;
    do begin
      tick();
      ena = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      din = noise ? 8'($urandom_range(0, 255)) : 8'h00;
      if (din == SYNC) din = 8'h5A;
      n++;
    end while (m_mode != 0 && n < 300);
    if (m_mode != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got mode %0d expected 0", m_mode);
    end
  endtask

  initial begin
    logic [7:0] pay4 [8];
    pay4 = '{8'hA5, 8'hA5, 8'h00, 8'hFF, 8'hA5, 8'h11, 8'h22, 8'h33};
    rst_n = 1'b0; ena = 1'b0; din = 8'h00; rd_ready = 1'b0;
    ena1 = 1'b0; din1 = 8'h00; rd_ready1 = 1'b0;
    @(posedge clk); #1; mon_en = 1'b1;
    @(posedge clk); #1;
    check("reset_busy1", {7'd0, busy1}, 8'd0);
    check("reset_valid1", {7'd0, rd_valid1}, 8'd0);
    tick(); rst_n = 1'b1;

    // Basic frame, host always ready
    ready_mode = 1;
    send(SYNC, 0);
    for (int i = 1; i <= 8; i++) send(8'(i), 0);
    wait_idle(1'b0);

    // ena toggling, random ready
    ready_mode = 2;
    send(SYNC, 1);
    for (int i = 1; i <= 8; i++) send(8'(i), 1);
    wait_idle(1'b0);

    // SYNC values inside the payload are data
    send(SYNC, 0);
    for (int i = 0; i < 8; i++) send(pay4[i], 0);
    wait_idle(1'b0);

    // Stalled drain with SYNC injected -> overflow, then a normal frame
    ready_mode = 0;
    send(SYNC, 0);
    for (int i = 0; i < 8; i++) send(8'h40 + 8'(i), 0);
    tick(); ena = 1'b1; din = SYNC;
    for (int i = 0; i < 4; i++) begin tick(); ena = 1'b0; end
    ready_mode = 1;
    wait_idle(1'b0);
    ready_mode = 2;
    send(SYNC, 0);
    for (int i = 0; i < 8; i++) send(8'($urandom_range(0, 255)), 0);
    wait_idle(1'b0);

    // Reset mid-capture, then a fresh frame
    send(SYNC, 0);
    for (int i = 0; i < 4; i++) send(8'h60 + 8'(i), 0);
    tick(); ena = 1'b0; rst_n = 1'b0;
    tick(); rst_n = 1'b1;
    send(SYNC, 0);
    for (int i = 0; i < 8; i++) send(8'h10 + 8'(i), 0);
    wait_idle(1'b0);

    // Randomised frames with idle noise and random gaps
    for (int f = 0; f < 8; f++) begin
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
        tick(); ena = 1'($urandom_range(0, 1)); din = 8'($urandom_range(0, 255));
        if (din == SYNC) din = 8'h00;
      end
      send(SYNC, int'($urandom_range(0, 2)));
      for (int i = 0; i < 8; i++) send(8'($urandom_range(0, 255)), int'($urandom_range(0, 2)));
      wait_idle(1'b1);
    end
    ready_mode = 0;

    // One-byte frame build
    tick(); ena1 = 1'b1; din1 = SYNC;
    tick(); din1 = 8'h3C;
    @(negedge clk);
    check("fl1_busy_cap", {7'd0, busy1}, 8'd1);
    check("fl1_valid_cap", {7'd0, rd_valid1}, 8'd0);
    tick(); ena1 = 1'b0; rd_ready1 = 1'b1;
    @(negedge clk);
    check("fl1_valid", {7'd0, rd_valid1}, 8'd1);
    check("fl1_data", rd_data1, 8'h3C);
    check("fl1_busy", {7'd0, busy1}, 8'd1);
    tick(); rd_ready1 = 1'b0;
    @(negedge clk);
    check("fl1_valid_end", {7'd0, rd_valid1}, 8'd0);
    check("fl1_data_end", rd_data1, 8'h00);
    check("fl1_busy_end", {7'd0, busy1}, 8'd0);
    check("fl1_overflow", {7'd0, overflow1}, 8'd0);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
